// File: rtl/rib_sram_ctrl.sv
// rib_sram_ctrl: RIB slave around a word-organised SRAM with a fixed-latency
// response pipeline, an in-order response FIFO and credit-based grant.
module rib_sram_ctrl #(
    parameter int unsigned DEPTH_WORDS  = 102400,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RSP_DEPTH    = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    output logic        o_ribs_err,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy
);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_fifoData [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] r_fifoErr;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_fifoCount;
    logic [CW-1:0] r_outstanding;

    logic          w_accept;
    logic          w_pop;
    logic          w_inRange;
    logic [32:0]   w_diff;
    logic [AW-1:0] w_index;
    logic [31:0]   w_s0Data;
    logic          w_s0Err;
    logic          w_pushValid;
    logic [31:0]   w_pushData;
    logic          w_pushErr;

    // A borrow out of the 33-bit subtraction pushes w_diff above SPAN, so a
    // single compare covers both the lower and the upper bound.
    assign w_diff    = {1'b0, i_ribs_addr} - {1'b0, BASE_ADDR};
    assign w_inRange = (w_diff < SPAN);
    assign w_index   = w_diff[AW+1:2];

    assign o_ribs_gnt = i_ribs_req & (r_outstanding < CW'(RSP_DEPTH));
    assign w_accept   = i_ribs_req & o_ribs_gnt;
    assign w_pop      = o_ribs_rsp & i_ribs_rdy;

    assign w_s0Data = (w_inRange & ~i_ribs_wrcs) ? r_mem[w_index] : 32'h0;
    assign w_s0Err  = ~w_inRange;

    always_ff @(posedge i_clk) begin
        if (w_accept && i_ribs_wrcs && w_inRange) begin
            for (int b = 0; b < 4; b++) begin
                if (i_ribs_mask[b]) r_mem[w_index][8*b +: 8] <= i_ribs_wdata[8*b +: 8];
            end
        end
    end

    // Reads and writes share one delay line so responses keep request order.
    if (READ_LATENCY == 1) begin : g_direct
        assign w_pushValid = w_accept;
        assign w_pushData  = w_s0Data;
        assign w_pushErr   = w_s0Err;
    end else begin : g_pipe
        localparam int unsigned NS = READ_LATENCY - 1;
        logic [NS-1:0]       r_pValid;
        logic [NS-1:0]       r_pErr;
        logic [NS-1:0][31:0] r_pData;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_pValid <= '0;
                r_pErr   <= '0;
                r_pData  <= '0;
            end else begin
                r_pValid <= (r_pValid << 1) | NS'(w_accept);
                r_pErr   <= (r_pErr << 1) | NS'(w_s0Err);
                r_pData  <= (r_pData << 32) | (NS*32)'(w_s0Data);
            end
        end

        assign w_pushValid = r_pValid[NS-1];
        assign w_pushData  = r_pData[NS-1];
        assign w_pushErr   = r_pErr[NS-1];
    end

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (w_pushValid) begin
            r_fifoData[r_wrPtr] <= w_pushData;
            r_fifoErr[r_wrPtr]  <= w_pushErr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_fifoCount   <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_pushValid) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)       r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_pushValid, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + CW'(1);
                2'b01:   r_fifoCount <= r_fifoCount - CW'(1);
                default: ;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase
        end
    end

    // Gating by rsp makes the outputs read zero straight out of reset.
    assign o_ribs_rsp   = (r_fifoCount != '0);
    assign o_ribs_rdata = o_ribs_rsp ? r_fifoData[r_rdPtr] : 32'h0;
    assign o_ribs_err   = o_ribs_rsp & r_fifoErr[r_rdPtr];

endmodule

// File: tb/tb_rib_sram_ctrl.sv
// tb_rib_sram_ctrl: directed scoreboard bench driving three rib_sram_ctrl
// configurations from one shared request bus, selected by 'sel'.
module tb_rib_sram_ctrl;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        wrcs = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        req = 1'b0;
    logic        rdy = 1'b0;
    int          sel = 0;

    logic        req0, req1, req2;
    logic        gnt0, gnt1, gnt2;
    logic        rsp0, rsp1, rsp2;
    logic        err0, err1, err2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        gnt, rsp, err;
    logic [31:0] rdata;

    logic        sGnt, sRsp, sErr;
    logic [31:0] sRdata;
    logic        rspSeen [10];

    rsp_t        expQ [$];
    logic [31:0] model [int];
    int          checkCount = 0;
    int          passCount = 0;

    always #10 clk = ~clk;

    assign req0 = req && (sel == 0);
    assign req1 = req && (sel == 1);
    assign req2 = req && (sel == 2);

    rib_sram_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .READ_LATENCY(1), .RSP_DEPTH(2)) uA (
        .i_clk(clk), .i_rst(rst), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs), .i_ribs_mask(mask),
        .i_ribs_wdata(wdata), .o_ribs_rdata(rdata0), .o_ribs_err(err0), .i_ribs_req(req0),
        .o_ribs_gnt(gnt0), .o_ribs_rsp(rsp0), .i_ribs_rdy(rdy));

    rib_sram_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .READ_LATENCY(2), .RSP_DEPTH(3)) uB (
        .i_clk(clk), .i_rst(rst), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs), .i_ribs_mask(mask),
        .i_ribs_wdata(wdata), .o_ribs_rdata(rdata1), .o_ribs_err(err1), .i_ribs_req(req1),
        .o_ribs_gnt(gnt1), .o_ribs_rsp(rsp1), .i_ribs_rdy(rdy));

    rib_sram_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h8000_0000), .READ_LATENCY(1), .RSP_DEPTH(2)) uC (
        .i_clk(clk), .i_rst(rst), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs), .i_ribs_mask(mask),
        .i_ribs_wdata(wdata), .o_ribs_rdata(rdata2), .o_ribs_err(err2), .i_ribs_req(req2),
        .o_ribs_gnt(gnt2), .o_ribs_rsp(rsp2), .i_ribs_rdy(rdy));

    always_comb begin
        gnt   = gnt0;
        rsp   = rsp0;
        rdata = rdata0;
        err   = err0;
        case (sel)
            1: begin gnt = gnt1; rsp = rsp1; rdata = rdata1; err = err1; end
            2: begin gnt = gnt2; rsp = rsp2; rdata = rdata2; err = err2; end
            default: ;
        endcase
    end

    function automatic logic [31:0] baseOf(input int s);
        return (s == 2) ? 32'h8000_0000 : 32'h0;
    endfunction

    function automatic longint spanOf(input int s);
        return (s == 2) ? 64 : 1024;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic q, input logic [31:0] a, input logic w,
                                 input logic [3:0] m, input logic [31:0] d, input logic r);
        req   = q;
        addr  = a;
        wrcs  = w;
        mask  = m;
        wdata = d;
        rdy   = r;
    endtask

    // Reference memory: an accepted request computes its expected response here.
    task automatic pushExpected();
        rsp_t        e;
        longint      off;
        int          key;
        logic [31:0] w;
        off = longint'(addr) - longint'(baseOf(sel));
        if (off < 0 || off >= spanOf(sel)) begin
            e = '{data: 32'h0, err: 1'b1};
        end else begin
            key = sel * 4096 + int'(off >>> 2);
            w = model.exists(key) ? model[key] : 32'h0;
            if (wrcs) begin
                for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
                model[key] = w;
                e = '{data: 32'h0, err: 1'b0};
            end else begin
                e = '{data: w, err: 1'b0};
            end
        end
        expQ.push_back(e);
    endtask

    task automatic step();
        rsp_t e;
        @(negedge clk);
        sGnt   = gnt;
        sRsp   = rsp;
        sRdata = rdata;
        sErr   = err;
        if (req && sGnt) pushExpected();
        if (sRsp && rdy) begin
            checkOutput("rsp_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rsp_data", sRdata, e.data);
                checkOutput("rsp_err", 32'(sErr), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
        int n = 0;
        applyStimulus(1'b1, a, w, m, d, 1'b1);
        step();
        while (!sGnt && n < 50) begin
            step();
            n++;
        end
        checkOutput("issue_granted", 32'(sGnt), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        while (expQ.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset pulse in the middle of an idle cycle.
        @(posedge clk);
        #3 rst = 1'b1;
        #2;
        checkOutput("rst_rsp", 32'(rsp0), 32'd0);
        checkOutput("rst_err", 32'(err0), 32'd0);
        checkOutput("rst_rdata", rdata0, 32'd0);
        rst = 1'b0;
        #1 req = 1'b1;
        #1 checkOutput("rst_gnt_req1", 32'(gnt0), 32'd1);
        req = 1'b0;
        #1 checkOutput("rst_gnt_req0", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1;

        // Masked write then read-after-write, latency 1.
        sel = 0;
        applyStimulus(1'b1, 32'h100, 1'b1, 4'hF, 32'h1122_3344, 1'b1);
        step();
        checkOutput("t2_pre_gnt", 32'(sGnt), 32'd1);
        applyStimulus(1'b1, 32'h100, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b1);
        step();
        checkOutput("t2_wr_gnt", 32'(sGnt), 32'd1);
        applyStimulus(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b1);
        step();
        checkOutput("t2_rd_gnt", 32'(sGnt), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        step();
        checkOutput("t2_rsp", 32'(sRsp), 32'd1);
        checkOutput("t2_rdata", sRdata, 32'h11BB_33DD);
        checkOutput("t2_err", 32'(sErr), 32'd0);
        drain();

        // Back-to-back reads, latency 2, depth 3.
        sel = 1;
        for (int i = 0; i < 8; i++) issue(32'(i * 4), 1'b1, 4'hF, 32'hB000_0000 + 32'(i) * 32'h0001_0101);
        drain();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, 4'h0, 32'h0, 1'b1);
            step();
            checkOutput($sformatf("t3_gnt%0d", i), 32'(sGnt), 32'd1);
            rspSeen[i] = sRsp;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        for (int i = 8; i < 10; i++) begin
            step();
            rspSeen[i] = sRsp;
        end
        for (int i = 0; i < 10; i++) checkOutput($sformatf("t3_rsp%0d", i), 32'(rspSeen[i]), (i >= 2) ? 32'd1 : 32'd0);
        drain();

        // Backpressure with two credits.
        sel = 0;
        issue(32'h200, 1'b1, 4'hF, 32'hD000_0000);
        issue(32'h204, 1'b1, 4'hF, 32'hD111_1111);
        issue(32'h208, 1'b1, 4'hF, 32'hD222_2222);
        drain();
        applyStimulus(1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0);
        step();
        checkOutput("t4_gnt_a", 32'(sGnt), 32'd1);
        applyStimulus(1'b1, 32'h204, 1'b0, 4'h0, 32'h0, 1'b0);
        step();
        checkOutput("t4_gnt_b", 32'(sGnt), 32'd1);
        applyStimulus(1'b1, 32'h208, 1'b0, 4'h0, 32'h0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step();
            checkOutput($sformatf("t4_hold_gnt%0d", j), 32'(sGnt), 32'd0);
            checkOutput($sformatf("t4_hold_rsp%0d", j), 32'(sRsp), 32'd1);
            checkOutput($sformatf("t4_hold_data%0d", j), sRdata, 32'hD000_0000);
        end
        applyStimulus(1'b1, 32'h208, 1'b0, 4'h0, 32'h0, 1'b1);
        step();
        checkOutput("t4_pop_cycle_gnt", 32'(sGnt), 32'd0);
        step();
        checkOutput("t4_after_pop_gnt", 32'(sGnt), 32'd1);
        drain();

        // Out-of-range access at a non-zero base.
        sel = 2;
        for (int i = 0; i < 16; i++) issue(32'h8000_0000 + 32'(i * 4), 1'b1, 4'hF, 32'h5A00_0000 | 32'(i));
        drain();
        issue(32'h8000_0040, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        step();
        checkOutput("t5_rsp", 32'(sRsp), 32'd1);
        checkOutput("t5_err", 32'(sErr), 32'd1);
        checkOutput("t5_rdata", sRdata, 32'd0);
        issue(32'h8000_0040, 1'b1, 4'hF, 32'hDEAD_BEEF);
        drain();
        for (int i = 0; i < 16; i++) issue(32'h8000_0000 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
        drain();

        // Reset with two reads outstanding.
        sel = 0;
        applyStimulus(1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0);
        step();
        checkOutput("t6_gnt_a", 32'(sGnt), 32'd1);
        applyStimulus(1'b1, 32'h204, 1'b0, 4'h0, 32'h0, 1'b0);
        step();
        checkOutput("t6_gnt_b", 32'(sGnt), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        #3;
        checkOutput("t6_pre_rsp", 32'(rsp0), 32'd1);
        rst = 1'b1;
        #2;
        checkOutput("t6_rst_rsp", 32'(rsp0), 32'd0);
        checkOutput("t6_rst_rdata", rdata0, 32'd0);
        expQ.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step();
            checkOutput($sformatf("t6_no_stale%0d", j), 32'(sRsp), 32'd0);
        end
        applyStimulus(1'b1, 32'h208, 1'b0, 4'h0, 32'h0, 1'b1);
        step();
        checkOutput("t6_gnt_after", 32'(sGnt), 32'd1);
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
